mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 255, max cycles a grant waits for mem_ack (1..255).
REQ-002 SHALL have one clock and a synchronous, active-low reset; ports in order:
  clk  in  1  clock, all state updates on rising edge
  rst  in  1  synchronous reset, active-low
  i_req  in  1  instruction-fetch request, held until i_ack
  i_addr  in  ADDR_W  fetch address
  i_ack  out  1  fetch complete, one-cycle pulse
  i_rdata  out  DATA_W  fetch data, valid when i_ack=1
  d_req  in  1  data request (MEM stage), held until d_ack
  d_we  in  1  1=store, 0=load
  d_addr  in  ADDR_W  data address
  d_wdata  in  DATA_W  store data
  d_ack  out  1  data access complete, one-cycle pulse
  d_rdata  out  DATA_W  load data, valid when d_ack=1
  stall_if  out  1  fetch stage must hold
  stall_mem  out  1  MEM stage must hold
  mem_req  out  1  single-port memory request, registered
  mem_we  out  1  memory write enable, registered
  mem_addr  out  ADDR_W  memory address, registered
  mem_wdata  out  DATA_W  memory write data, registered
  mem_ack  in  1  memory completion; may assert in any cycle mem_req=1, including the first
  mem_rdata  in  DATA_W  memory read data, valid with mem_ack
  err  out  1  sticky timeout flag

Function
REQ-003 SHALL implement FSM states IDLE, GNT_I, GNT_D; mem_req=1 exactly in GNT_I and GNT_D.
REQ-004 IDLE: d_req=1 -> GNT_D; else i_req=1 -> GNT_I; else stay; d_req and i_req both 1 -> GNT_D (data priority, older instruction).
REQ-005 On entering GNT_D SHALL register mem_addr=d_addr, mem_we=d_we, mem_wdata=d_wdata; on entering GNT_I mem_addr=i_addr, mem_we=0, mem_wdata=0.
REQ-006 mem_addr/mem_we/mem_wdata SHALL hold constant for whole grant regardless of requester input changes.
REQ-007 In GNT_x with mem_ack=1: x_ack=1 same cycle (combinational), x_rdata=mem_rdata; otherwise x_ack=0, x_rdata=0.
REQ-008 d_rdata on a store ack SHALL equal mem_rdata (don't-care for requester, deterministic for bench).
REQ-009 On ack cycle SHALL re-arbitrate excluding the just-served requester (its req is stale): other requester pending -> grant it next cycle, no IDLE bubble; else -> IDLE.
REQ-010 Consequence: with both requesters continuously active, grants SHALL strictly alternate; neither starves.
REQ-011 stall_if = i_req & ~i_ack; stall_mem = d_req & ~d_ack (combinational).
REQ-012 8-bit wait counter SHALL clear on every grant entry and increment each GNT_x cycle without mem_ack.
REQ-013 When wait counter = TIMEOUT-1 and mem_ack=0: SHALL pulse x_ack with x_rdata=0, set err=1, drop grant per REQ-009.
REQ-014 err SHALL remain 1 until reset; arbitration continues normally after a timeout.
REQ-015 mem_ack in IDLE SHALL be ignored (no ack, no state change).
REQ-016 Minimum latency: request sampled in cycle n -> mem_req=1 in n+1 -> earliest ack in n+1.

Reset
REQ-017 rst=0 at a rising edge SHALL force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wait counter=0, err=0; i_ack=d_ack=0 while in IDLE.
REQ-018 Reset mid-grant SHALL abandon the access without acking; requester reissues after reset.

Verification
REQ-019 Single fetch: i_req=1, i_addr=0x40, mem_ack 2 cycles after mem_req with rdata 0x2002000A -> mem_addr=0x40, mem_we=0, i_ack one cycle, i_rdata=0x2002000A, back to IDLE.
REQ-020 Collision: i_req and d_req (store, addr 0x10, wdata 0x55) both rise same cycle -> GNT_D first (mem_we=1, addr 0x10), then GNT_I with no IDLE gap; stall_if=1 throughout data grant.
REQ-021 Saturation: both reqs held high for 10 accesses, mem_ack immediate -> grant sequence D,I,D,I,...; one ack per cycle.
REQ-022 Timeout: TIMEOUT=4, d_req load, mem_ack never -> d_ack on 4th grant cycle, d_rdata=0, err=1 and stays 1 through later normal fetch.
REQ-023 Reset mid-operation: rst=0 during GNT_I before mem_ack -> next cycle IDLE, mem_req=0, err=0, no i_ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data wins collisions; the just-served side is excluded on its ack cycle so both alternate.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_r;
    state_t     nextState_s;
    logic [7:0] waitCnt_r;
    logic       lastWait_s;
    logic       done_s;
    logic       timeout_s;
    logic       enterGnt_s;

    // Next-state selection plus combinational ack/rdata toward the requesters
    always_comb begin
        nextState_s = state_r;
        i_ack       = 1'b0;
        d_ack       = 1'b0;
        i_rdata     = {DATA_W{1'b0}};
        d_rdata     = {DATA_W{1'b0}};
        lastWait_s  = (waitCnt_r == WAIT_LAST);
        done_s      = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (d_req) begin
                    nextState_s = GNT_D;
                end else if (i_req) begin
                    nextState_s = GNT_I;
                end else begin
                    nextState_s = IDLE;
                end
            end
            GNT_I: begin
                done_s    = mem_ack | lastWait_s;
                timeout_s = ~mem_ack & lastWait_s;
                i_ack     = done_s;
                i_rdata   = mem_ack ? mem_rdata : {DATA_W{1'b0}};
                // The served side's request is stale on its ack cycle, so only the other side counts
                if (done_s) begin
                    nextState_s = d_req ? GNT_D : IDLE;
                end else begin
                    nextState_s = GNT_I;
                end
            end
            GNT_D: begin
                done_s    = mem_ack | lastWait_s;
                timeout_s = ~mem_ack & lastWait_s;
                d_ack     = done_s;
                d_rdata   = mem_ack ? mem_rdata : {DATA_W{1'b0}};
                if (done_s) begin
                    nextState_s = i_req ? GNT_I : IDLE;
                end else begin
                    nextState_s = GNT_D;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
        enterGnt_s = (nextState_s != IDLE) && ((state_r == IDLE) || done_s);
    end

    assign stall_if  = i_req & ~i_ack;
    assign stall_mem = d_req & ~d_ack;

    // State register and registered memory request
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            mem_req <= 1'b0;
        end else begin
            state_r <= nextState_s;
            mem_req <= (nextState_s != IDLE);
        end
    end

    // Memory command capture on grant entry; held constant for the whole grant
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
        end else if (enterGnt_s) begin
            if (nextState_s == GNT_D) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else begin
                mem_we    <= 1'b0;
                mem_addr  <= i_addr;
                mem_wdata <= {DATA_W{1'b0}};
            end
        end else begin
            mem_we    <= mem_we;
            mem_addr  <= mem_addr;
            mem_wdata <= mem_wdata;
        end
    end

    // Wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            waitCnt_r <= 8'd0;
            err       <= 1'b0;
        end else begin
            if (enterGnt_s) begin
                waitCnt_r <= 8'd0;
            end else if ((state_r != IDLE) && !mem_ack) begin
                waitCnt_r <= waitCnt_r + 8'd1;
            end else begin
                waitCnt_r <= waitCnt_r;
            end
            err <= err | timeout_s;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus
// hand-written saturation, timeout and mid-grant reset sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        iReq, dReq, dWe, memAck;
    logic [31:0] iAddr, dAddr, dWdata, memRdata;
    logic        iAck, dAck, stallIf, stallMem, memReq, memWe, err;
    logic [31:0] iRdata, dRdata, memAddr, memWdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(iReq), .i_addr(iAddr), .i_ack(iAck), .i_rdata(iRdata),
        .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
        .d_ack(dAck), .d_rdata(dRdata),
        .stall_if(stallIf), .stall_mem(stallMem),
        .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_ack(memAck), .mem_rdata(memRdata), .err(err)
    );

    typedef struct {
        logic        iReq;
        logic [31:0] iAddr;
        logic        dReq;
        logic        dWe;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        logic        memAck;
        logic [31:0] memRdata;
        logic        eMemReq;
        logic        eMemWe;
        logic [31:0] eMemAddr;
        logic [31:0] eMemWdata;
        logic        eIAck;
        logic [31:0] eIRdata;
        logic        eDAck;
        logic [31:0] eDRdata;
        logic        eStallIf;
        logic        eStallMem;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] dwd, input logic ma, input logic [31:0] mr,
        input logic emq, input logic emw, input logic [31:0] ema, input logic [31:0] emd,
        input logic eia, input logic [31:0] eir, input logic eda, input logic [31:0] edr,
        input logic esi, input logic esm);
        vec_t v;
        v.iReq = ir; v.iAddr = ia; v.dReq = dr; v.dWe = dw; v.dAddr = da; v.dWdata = dwd;
        v.memAck = ma; v.memRdata = mr; v.eMemReq = emq; v.eMemWe = emw; v.eMemAddr = ema;
        v.eMemWdata = emd; v.eIAck = eia; v.eIRdata = eir; v.eDAck = eda; v.eDRdata = edr;
        v.eStallIf = esi; v.eStallMem = esm;
        return v;
    endfunction

    initial begin
        // Row = one cycle; the state column is the state during that cycle
        vecs[0]  = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,  1, 32'hDEAD,     0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 32'h0,    0, 0); // IDLE, stray mem_ack
        vecs[1]  = mk(1, 32'h40, 0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 32'h0,    1, 0); // IDLE, fetch req
        vecs[2]  = mk(1, 32'h40, 0, 0, 32'h0,  32'h0,  0, 32'h0,        1, 0, 32'h40, 32'h0,  0, 32'h0,        0, 32'h0,    1, 0); // GNT_I wait 1
        vecs[3]  = mk(1, 32'h44, 0, 0, 32'h0,  32'h0,  0, 32'h0,        1, 0, 32'h40, 32'h0,  0, 32'h0,        0, 32'h0,    1, 0); // GNT_I wait 2, addr held
        vecs[4]  = mk(1, 32'h44, 0, 0, 32'h0,  32'h0,  1, 32'h2002000A, 1, 0, 32'h40, 32'h0,  1, 32'h2002000A, 0, 32'h0,    0, 0); // GNT_I ack
        vecs[5]  = mk(1, 32'h80, 1, 1, 32'h10, 32'h55, 0, 32'h0,        0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 32'h0,    1, 1); // IDLE, collision
        vecs[6]  = mk(1, 32'h80, 1, 1, 32'h99, 32'h77, 0, 32'h0,        1, 1, 32'h10, 32'h55, 0, 32'h0,        0, 32'h0,    1, 1); // GNT_D store, inputs move
        vecs[7]  = mk(1, 32'h80, 1, 1, 32'h99, 32'h77, 1, 32'h1234,     1, 1, 32'h10, 32'h55, 0, 32'h0,        1, 32'h1234, 1, 0); // GNT_D ack
        vecs[8]  = mk(1, 32'h80, 0, 0, 32'h0,  32'h0,  1, 32'hCAFE,     1, 0, 32'h80, 32'h0,  1, 32'hCAFE,     0, 32'h0,    0, 0); // GNT_I, no bubble
        vecs[9]  = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 32'h0,    0, 0); // IDLE
        vecs[10] = mk(0, 32'h0,  1, 0, 32'h20, 32'hFF, 0, 32'h0,        0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 32'h0,    0, 1); // IDLE, load req
        vecs[11] = mk(0, 32'h0,  1, 0, 32'h20, 32'hFF, 1, 32'hBEEF,     1, 0, 32'h20, 32'hFF, 0, 32'h0,        1, 32'hBEEF, 0, 0); // GNT_D immediate ack
        vecs[12] = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,  1, 32'h1,        0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 32'h0,    0, 0); // IDLE, stray mem_ack

        rst = 1'b0; iReq = 1'b0; iAddr = 32'h0; dReq = 1'b0; dWe = 1'b0;
        dAddr = 32'h0; dWdata = 32'h0; memAck = 1'b0; memRdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("reset mem_req", {31'h0, memReq}, 32'h0);
        chk("reset mem_we", {31'h0, memWe}, 32'h0);
        chk("reset mem_addr", memAddr, 32'h0);
        chk("reset mem_wdata", memWdata, 32'h0);
        chk("reset err", {31'h0, err}, 32'h0);
        chk("reset acks", {30'h0, iAck, dAck}, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < 13; r++) begin
            @(negedge clk);
            iReq = vecs[r].iReq; iAddr = vecs[r].iAddr; dReq = vecs[r].dReq; dWe = vecs[r].dWe;
            dAddr = vecs[r].dAddr; dWdata = vecs[r].dWdata; memAck = vecs[r].memAck;
            memRdata = vecs[r].memRdata;
            #2;
            chk($sformatf("row%0d mem_req", r), {31'h0, memReq}, {31'h0, vecs[r].eMemReq});
            if (vecs[r].eMemReq) begin
                chk($sformatf("row%0d mem_we", r), {31'h0, memWe}, {31'h0, vecs[r].eMemWe});
                chk($sformatf("row%0d mem_addr", r), memAddr, vecs[r].eMemAddr);
                chk($sformatf("row%0d mem_wdata", r), memWdata, vecs[r].eMemWdata);
            end
            chk($sformatf("row%0d i_ack", r), {31'h0, iAck}, {31'h0, vecs[r].eIAck});
            chk($sformatf("row%0d i_rdata", r), iRdata, vecs[r].eIRdata);
            chk($sformatf("row%0d d_ack", r), {31'h0, dAck}, {31'h0, vecs[r].eDAck});
            chk($sformatf("row%0d d_rdata", r), dRdata, vecs[r].eDRdata);
            chk($sformatf("row%0d stall_if", r), {31'h0, stallIf}, {31'h0, vecs[r].eStallIf});
            chk($sformatf("row%0d stall_mem", r), {31'h0, stallMem}, {31'h0, vecs[r].eStallMem});
            chk($sformatf("row%0d err", r), {31'h0, err}, 32'h0);
        end

        // Saturation: both requesters held, immediate acks -> D,I,D,I...
        @(negedge clk);
        iReq = 1'b1; iAddr = 32'h60; dReq = 1'b1; dWe = 1'b1; dAddr = 32'h64; dWdata = 32'hAA;
        memAck = 1'b1; memRdata = 32'h100;
        #2;
        chk("sat idle mem_req", {31'h0, memReq}, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            #2;
            chk($sformatf("sat%0d mem_req", k), {31'h0, memReq}, 32'h1);
            chk($sformatf("sat%0d mem_we", k), {31'h0, memWe}, {31'h0, k[0]});
            chk($sformatf("sat%0d mem_addr", k), memAddr, k[0] ? 32'h64 : 32'h60);
            chk($sformatf("sat%0d d_ack", k), {31'h0, dAck}, {31'h0, k[0]});
            chk($sformatf("sat%0d i_ack", k), {31'h0, iAck}, {31'h0, ~k[0]});
        end
        @(negedge clk);
        iReq = 1'b0; dReq = 1'b0;
        @(negedge clk);
        memAck = 1'b0;
        #2;
        chk("sat drain mem_req", {31'h0, memReq}, 32'h0);

        // Timeout: load never acked, TIMEOUT=4
        @(negedge clk);
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h30; memAck = 1'b0; memRdata = 32'h5555;
        #2;
        chk("to idle d_ack", {31'h0, dAck}, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #2;
            chk($sformatf("to%0d mem_req", k), {31'h0, memReq}, 32'h1);
            chk($sformatf("to%0d d_ack", k), {31'h0, dAck}, (k == 4) ? 32'h1 : 32'h0);
            chk($sformatf("to%0d d_rdata", k), dRdata, 32'h0);
            chk($sformatf("to%0d err", k), {31'h0, err}, 32'h0);
        end
        @(negedge clk);
        dReq = 1'b0;
        #2;
        chk("to after mem_req", {31'h0, memReq}, 32'h0);
        chk("to after err", {31'h0, err}, 32'h1);
        @(negedge clk);
        iReq = 1'b1; iAddr = 32'h44; memAck = 1'b1; memRdata = 32'h77;
        #2;
        chk("to fetch idle i_ack", {31'h0, iAck}, 32'h0);
        @(negedge clk);
        #2;
        chk("to fetch i_ack", {31'h0, iAck}, 32'h1);
        chk("to fetch i_rdata", iRdata, 32'h77);
        chk("to fetch err", {31'h0, err}, 32'h1);
        @(negedge clk);
        iReq = 1'b0; memAck = 1'b0;
        #2;
        chk("to sticky err", {31'h0, err}, 32'h1);

        // Reset during GNT_I before mem_ack
        @(negedge clk);
        iReq = 1'b1; iAddr = 32'h50;
        #2;
        @(negedge clk);
        #2;
        chk("rst grant mem_req", {31'h0, memReq}, 32'h1);
        chk("rst grant mem_addr", memAddr, 32'h50);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst cycle i_ack", {31'h0, iAck}, 32'h0);
        @(negedge clk);
        rst = 1'b1; iReq = 1'b0;
        #2;
        chk("rst after mem_req", {31'h0, memReq}, 32'h0);
        chk("rst after err", {31'h0, err}, 32'h0);
        chk("rst after i_ack", {31'h0, iAck}, 32'h0);
        chk("rst after mem_addr", memAddr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
